// File: rtl/hist_pkg.sv
// rtl/hist_pkg.sv - shared state encoding and sizing helpers for the histogram engine
package hist_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ACCUM,
        S_DRAIN1,
        S_DRAIN2,
        S_DONE
    } hist_state_t;

    // Number of bins for a given bin-index width
    function automatic int unsigned nbins(input int unsigned bin_bits);
        return 32'd1 << bin_bits;
    endfunction

    // All-ones saturation ceiling for a counter of the given width
    function automatic logic [63:0] sat_max(input int unsigned width);
        return (64'd1 << width) - 64'd1;
    endfunction

endpackage

// File: rtl/hist_ram.sv
// rtl/hist_ram.sv - bin storage, one write port and one synchronous read port
module hist_ram #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 24
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data
);

    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Write port and read-first registered read port; contents are never reset
    always_ff @(posedge clk) begin
        if (we) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/hist_engine.sv
// rtl/hist_engine.sv - per-frame pixel histogram with peak tracking and bin readback
module hist_engine
    import hist_pkg::*;
#(
    parameter int PIX_WIDTH   = 8,
    parameter int BIN_BITS    = 8,
    parameter int COUNT_WIDTH = 24
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    input  logic                   pixel_valid,
    input  logic [PIX_WIDTH-1:0]   pixel_in,
    input  logic                   in_last,
    output logic                   ready,
    input  logic [BIN_BITS-1:0]    rd_addr,
    output logic [COUNT_WIDTH-1:0] rd_data,
    output logic [COUNT_WIDTH-1:0] pix_count,
    output logic [BIN_BITS-1:0]    peak_bin,
    output logic [COUNT_WIDTH-1:0] peak_count
);

    localparam int unsigned NBINS = nbins(BIN_BITS);
    localparam logic [COUNT_WIDTH-1:0] CNT_MAX = COUNT_WIDTH'(sat_max(COUNT_WIDTH));

    hist_state_t state, state_next;

    logic [BIN_BITS-1:0]    clr_idx, s1_bin, lw_addr, pix_bin;
    logic [BIN_BITS-1:0]    ram_raddr, ram_waddr;
    logic [COUNT_WIDTH-1:0] lw_data, ram_q, ram_wdata, old_cnt, new_cnt;
    logic                   s1_valid, lw_valid, last_pending, ram_we, accept, rd_ok;

    assign pix_bin = pixel_in[PIX_WIDTH-1 -: BIN_BITS];
    assign accept  = pixel_valid & ready;
    assign rd_data = rd_ok ? ram_q : '0;

    hist_ram #(
        .ADDR_WIDTH(BIN_BITS),
        .DATA_WIDTH(COUNT_WIDTH)
    ) u_ram (
        .clk    (clk),
        .we     (ram_we),
        .wr_addr(ram_waddr),
        .wr_data(ram_wdata),
        .rd_addr(ram_raddr),
        .rd_data(ram_q)
    );

    // Next state and status outputs; ACCUM stops accepting once the last beat is in
    always_comb begin
        state_next = state;
        busy       = 1'b1;
        done       = 1'b0;
        ready      = 1'b0;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (start) state_next = S_CLEAR;
            end
            S_CLEAR: begin
                if (clr_idx == BIN_BITS'(NBINS - 1)) state_next = S_ACCUM;
            end
            S_ACCUM: begin
                ready = !last_pending;
                if (last_pending) state_next = S_DRAIN1;
            end
            S_DRAIN1: state_next = S_DRAIN2;
            S_DRAIN2: state_next = S_DONE;
            S_DONE: begin
                done       = 1'b1;
                state_next = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase
    end

    // RAM port steering: clear sweep, or the write half of the read-modify-write
    // with the previous cycle's write forwarded because the RAM reads old data
    always_comb begin
        old_cnt   = (lw_valid && (lw_addr == s1_bin)) ? lw_data : ram_q;
        new_cnt   = (old_cnt == CNT_MAX) ? old_cnt : old_cnt + COUNT_WIDTH'(1);
        ram_we    = 1'b0;
        ram_waddr = s1_bin;
        ram_wdata = new_cnt;
        if (state == S_CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_idx;
            ram_wdata = '0;
        end else if (s1_valid) begin
            ram_we = 1'b1;
        end
        ram_raddr = accept ? pix_bin : rd_addr;
    end

    // State, pipeline and frame statistics registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= S_IDLE;
            clr_idx      <= '0;
            s1_valid     <= 1'b0;
            s1_bin       <= '0;
            last_pending <= 1'b0;
            lw_valid     <= 1'b0;
            lw_addr      <= '0;
            lw_data      <= '0;
            rd_ok        <= 1'b0;
            pix_count    <= '0;
            peak_bin     <= '0;
            peak_count   <= '0;
        end else begin
            state    <= state_next;
            s1_valid <= accept;
            s1_bin   <= pix_bin;
            lw_valid <= ram_we;
            lw_addr  <= ram_waddr;
            lw_data  <= ram_wdata;
            rd_ok    <= (state_next == S_IDLE);
            if (state == S_IDLE && start) begin
                clr_idx      <= '0;
                last_pending <= 1'b0;
                pix_count    <= '0;
                peak_bin     <= '0;
                peak_count   <= '0;
            end
            if (state == S_CLEAR) begin
                clr_idx <= clr_idx + BIN_BITS'(1);
            end
            if (accept) begin
                if (in_last) last_pending <= 1'b1;
                if (pix_count != CNT_MAX) pix_count <= pix_count + COUNT_WIDTH'(1);
            end
            if (s1_valid && (new_cnt > peak_count)) begin
                peak_bin   <= s1_bin;
                peak_count <= new_cnt;
            end
        end
    end

endmodule

// File: tb/tb_hist_engine.sv
// tb/tb_hist_engine.sv - scoreboard bench for hist_engine across three parameter sets
module tb_hist_engine;

    typedef struct {
        int inst;
        int kind;
        int a;
        int b;
        int c;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    logic start_s [3];
    logic pv      [3];
    logic lst     [3];
    logic rdq     [3];
    logic rdq_d   [3];
    logic [7:0] pin   [3];
    logic [7:0] raddr [3];

    logic        busy0, done0, ready0, busy1, done1, ready1, busy2, done2, ready2;
    logic [23:0] rd0, pc0, pk0, rd1, pc1, pk1;
    logic [7:0]  pb0, pb2;
    logic [3:0]  pb1, rd2, pc2, pk2;

    logic        busy_w  [3];
    logic        done_w  [3];
    logic        ready_w [3];
    logic [31:0] rd_w    [3];
    logic [31:0] pc_w    [3];
    logic [31:0] pkb_w   [3];
    logic [31:0] pkc_w   [3];

    exp_t       sb[$];
    logic [7:0] pix_q[$];
    int         acc_edge [3];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    hist_engine u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start_s[0]), .busy(busy0), .done(done0),
        .pixel_valid(pv[0]), .pixel_in(pin[0]), .in_last(lst[0]), .ready(ready0),
        .rd_addr(raddr[0]), .rd_data(rd0), .pix_count(pc0), .peak_bin(pb0), .peak_count(pk0)
    );

    hist_engine #(.PIX_WIDTH(8), .BIN_BITS(4), .COUNT_WIDTH(24)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start_s[1]), .busy(busy1), .done(done1),
        .pixel_valid(pv[1]), .pixel_in(pin[1]), .in_last(lst[1]), .ready(ready1),
        .rd_addr(raddr[1][3:0]), .rd_data(rd1), .pix_count(pc1), .peak_bin(pb1), .peak_count(pk1)
    );

    hist_engine #(.PIX_WIDTH(8), .BIN_BITS(8), .COUNT_WIDTH(4)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start_s[2]), .busy(busy2), .done(done2),
        .pixel_valid(pv[2]), .pixel_in(pin[2]), .in_last(lst[2]), .ready(ready2),
        .rd_addr(raddr[2]), .rd_data(rd2), .pix_count(pc2), .peak_bin(pb2), .peak_count(pk2)
    );

    assign busy_w[0] = busy0;   assign busy_w[1] = busy1;   assign busy_w[2] = busy2;
    assign done_w[0] = done0;   assign done_w[1] = done1;   assign done_w[2] = done2;
    assign ready_w[0] = ready0; assign ready_w[1] = ready1; assign ready_w[2] = ready2;
    assign rd_w[0]  = 32'(rd0); assign rd_w[1]  = 32'(rd1); assign rd_w[2]  = 32'(rd2);
    assign pc_w[0]  = 32'(pc0); assign pc_w[1]  = 32'(pc1); assign pc_w[2]  = 32'(pc2);
    assign pkb_w[0] = 32'(pb0); assign pkb_w[1] = 32'(pb1); assign pkb_w[2] = 32'(pb2);
    assign pkc_w[0] = 32'(pk0); assign pkc_w[1] = 32'(pk1); assign pkc_w[2] = 32'(pk2);

    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int i = 0; i < 3; i++) rdq_d[i] <= rdq[i];
    end

    task automatic chk(input string nm, input longint act, input longint expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, expv);
        end
    endtask

    // Monitor: pops the next expectation whenever a DUT presents done or read data
    always @(negedge clk) begin : monitor
        exp_t e;
        for (int i = 0; i < 3; i++) begin
            if (done_w[i] || rdq_d[i]) begin
                if (sb.size() == 0) begin
                    chk($sformatf("inst%0d unexpected_output", i), 1, 0);
                end else begin
                    e = sb.pop_front();
                    if (done_w[i]) begin
                        chk($sformatf("inst%0d done_order", i), e.inst * 2 + e.kind, i * 2);
                        chk($sformatf("inst%0d pix_count", i), pc_w[i], e.a);
                        chk($sformatf("inst%0d peak_bin", i), pkb_w[i], e.b);
                        chk($sformatf("inst%0d peak_count", i), pkc_w[i], e.c);
                        chk($sformatf("inst%0d done_latency", i), cyc - acc_edge[i], 3);
                    end else begin
                        chk($sformatf("inst%0d read_order", i), e.inst * 2 + e.kind, i * 2 + 1);
                        chk($sformatf("inst%0d rd_data bin%0d", i, e.b), rd_w[i], e.a);
                    end
                end
            end
        end
    end

    task automatic read_bin(input int i, input int addr, input int expv);
        exp_t e;
        e = '{i, 1, expv, addr, 0};
        sb.push_back(e);
        raddr[i] = 8'(addr);
        rdq[i]   = 1'b1;
        @(posedge clk);
        #1 rdq[i] = 1'b0;
    endtask

    task automatic check_zero_outputs(input int i, input string tag);
        chk({tag, " busy"}, busy_w[i], 0);
        chk({tag, " done"}, done_w[i], 0);
        chk({tag, " ready"}, ready_w[i], 0);
        chk({tag, " rd_data"}, rd_w[i], 0);
        chk({tag, " pix_count"}, pc_w[i], 0);
        chk({tag, " peak_bin"}, pkb_w[i], 0);
        chk({tag, " peak_count"}, pkc_w[i], 0);
    endtask

    // Start a frame with a junk beat (valid and in_last high) offered throughout CLEAR
    task automatic begin_frame(input int i, input int nb, input bit hold);
        int n;
        start_s[i] = 1'b1;
        pv[i]      = 1'b1;
        pin[i]     = 8'hAA;
        lst[i]     = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) start_s[i] = 1'b0;
        n = 0;
        while (n <= nb + 2) begin
            @(negedge clk);
            if (ready_w[i]) break;
            if (n == 1) begin
                chk($sformatf("inst%0d busy_in_clear", i), busy_w[i], 1);
                chk($sformatf("inst%0d rd_data_in_clear", i), rd_w[i], 0);
            end
            n++;
        end
        chk($sformatf("inst%0d clear_cycles", i), n, nb);
    endtask

    task automatic send_beats(input int i, input bit gap, input bit do_last);
        for (int j = 0; j < pix_q.size(); j++) begin
            while (gap && ($urandom_range(0, 2) == 0)) begin
                pv[i] = 1'b0;
                @(negedge clk);
            end
            chk($sformatf("inst%0d ready_beat%0d", i, j), ready_w[i], 1);
            pv[i]  = 1'b1;
            pin[i] = pix_q[j];
            lst[i] = do_last && (j == pix_q.size() - 1);
            @(posedge clk);
            #1;
            acc_edge[i] = cyc;
            pv[i]  = 1'b0;
            lst[i] = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic wait_done(input int i);
        int n;
        n = 0;
        while (n < 20) begin
            if (done_w[i]) break;
            @(negedge clk);
            n++;
        end
        if (n >= 20) chk($sformatf("inst%0d done_timeout", i), 0, 1);
        @(posedge clk);
        #1 start_s[i] = 1'b0;
        @(negedge clk);
        chk($sformatf("inst%0d idle_after_done", i), busy_w[i], 0);
        @(negedge clk);
        chk($sformatf("inst%0d no_restart", i), busy_w[i], 0);
    endtask

    task automatic run_frame(input int i, input int nb, input bit hold, input bit gap,
                             input int pix, input int pb, input int pc);
        exp_t e;
        e = '{i, 0, pix, pb, pc};
        sb.push_back(e);
        begin_frame(i, nb, hold);
        send_beats(i, gap, 1'b1);
        wait_done(i);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            start_s[i] = 1'b0; pv[i] = 1'b0; lst[i] = 1'b0; rdq[i] = 1'b0;
            pin[i] = '0; raddr[i] = '0; acc_edge[i] = 0;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_zero_outputs(0, "reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Three identical values back to back then a different bin
        pix_q = '{8'h10, 8'h10, 8'h10, 8'h20};
        run_frame(0, 256, 1'b0, 1'b0, 4, 'h10, 3);
        read_bin(0, 'h10, 3);
        read_bin(0, 'h20, 1);
        read_bin(0, 'h00, 0);
        read_bin(0, 'hFF, 0);

        // start held through ACCUM and DONE; later peak wins only when strictly greater
        pix_q = '{8'h10, 8'h20, 8'h20};
        run_frame(0, 256, 1'b1, 1'b0, 3, 'h20, 2);
        pix_q = '{8'h40};
        run_frame(0, 256, 1'b0, 1'b0, 1, 'h40, 1);
        read_bin(0, 'h10, 0);
        read_bin(0, 'h20, 0);
        read_bin(0, 'h40, 1);

        // Reset in the middle of accumulation
        pix_q = '{8'h33, 8'h33};
        begin_frame(0, 256, 1'b0);
        send_beats(0, 1'b0, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_zero_outputs(0, "mid_reset");
        pix_q = '{8'h01, 8'h01};
        run_frame(0, 256, 1'b0, 1'b0, 2, 'h01, 2);
        read_bin(0, 'h01, 2);
        read_bin(0, 'h33, 0);
        read_bin(0, 'h00, 0);

        // Random valid gaps
        pix_q = '{8'h80, 8'h81, 8'h80, 8'h7F, 8'h80, 8'h22, 8'h22, 8'h7F};
        run_frame(0, 256, 1'b0, 1'b1, 8, 'h80, 3);
        read_bin(0, 'h80, 3);
        read_bin(0, 'h81, 1);
        read_bin(0, 'h7F, 2);
        read_bin(0, 'h22, 2);
        read_bin(0, 'hAA, 0);

        // 16 bins: top nibble selects the bin, tie keeps the earlier peak
        pix_q = '{8'h00, 8'h0F, 8'hF0, 8'hFF};
        run_frame(1, 16, 1'b0, 1'b0, 4, 0, 2);
        read_bin(1, 0, 2);
        read_bin(1, 15, 2);
        read_bin(1, 1, 0);

        // 4-bit counters saturate
        pix_q.delete();
        for (int k = 0; k < 20; k++) pix_q.push_back(8'h55);
        run_frame(2, 256, 1'b0, 1'b0, 15, 'h55, 15);
        read_bin(2, 'h55, 15);
        read_bin(2, 'h54, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
